// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pix_en-strobed h/v counters with registered sync,
// data-enable and line/frame strobes, plus an optional pix_en-clocked delay line.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned PIPE_STAGES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned SR_LEN  = (PIPE_STAGES > 0) ? PIPE_STAGES : 1;

    generate
        if ((H_TOTAL > (2 ** CNT_W)) || (V_TOTAL > (2 ** CNT_W))) begin : g_bad_cnt_w
            $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
        if (PIPE_STAGES > 4) begin : g_bad_pipe
            $error("vga_timing_gen: PIPE_STAGES must be 0..4");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_DE   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_DE   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic frame_start;
        logic line_start;
        logic vsync;
        logic hsync;
        logic de;
    } dec_t;

    localparam dec_t DEC_IDLE = '{1'b0, 1'b0, ~VS_POL, ~HS_POL, 1'b0};

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W-1:0] h_next, v_next;
    dec_t             dec_next;
    dec_t             tap;
    dec_t             sr [SR_LEN];

    always_comb begin
        h_next = h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    // Decode the counts that will be loaded, so outputs carry zero latency vs pix_x/pix_y.
    always_comb begin
        dec_next             = DEC_IDLE;
        dec_next.de          = (h_next < H_DE) && (v_next < V_DE);
        dec_next.hsync       = ((h_next >= H_SS) && (h_next < H_SE)) ? HS_POL : ~HS_POL;
        dec_next.vsync       = ((v_next >= V_SS) && (v_next < V_SE)) ? VS_POL : ~VS_POL;
        dec_next.line_start  = (h_next == '0);
        dec_next.frame_start = (h_next == '0) && (v_next == '0);
    end

    always_comb begin
        if (PIPE_STAGES == 0) tap = dec_next;
        else                  tap = sr[SR_LEN-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            for (int unsigned i = 0; i < SR_LEN; i++) sr[i] <= DEC_IDLE;
        end else begin
            // Strobes drop on idle clks so they stay one clk wide at any pix_en rate.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                h_cnt       <= h_next;
                v_cnt       <= v_next;
                sr[0]       <= dec_next;
                for (int unsigned i = 1; i < SR_LEN; i++) sr[i] <= sr[i-1];
                de          <= tap.de;
                hsync       <= tap.hsync;
                vsync       <= tap.vsync;
                line_start  <= tap.line_start;
                frame_start <= tap.frame_start;
            end
        end
    end

    assign pix_x = h_cnt;
    assign pix_y = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a reduced-raster instance with
// active-high syncs for vertical/frame checks, and a PIPE_STAGES=2 instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en_a, pix_en_b, pix_en_c;

    logic [9:0] x_a, y_a, x_c, y_c;
    logic [4:0] x_b, y_b;
    logic de_a, hs_a, vs_a, ls_a, fs_a;
    logic de_b, hs_b, vs_b, ls_b, fs_b;
    logic de_c, hs_c, vs_c, ls_c, fs_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en_a), .pix_x(x_a), .pix_y(y_a),
        .de(de_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
    );

    // 16 x 12 raster: hsync h 10..12, vsync v 8..9, both active-high.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(5), .PIPE_STAGES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en_b), .pix_x(x_b), .pix_y(y_b),
        .de(de_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(.PIPE_STAGES(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en_c), .pix_x(x_c), .pix_y(y_c),
        .de(de_c), .hsync(hs_c), .vsync(vs_c), .line_start(ls_c), .frame_start(fs_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_en_a = 1'b0; pix_en_b = 1'b0; pix_en_c = 1'b0;
        repeat (3) tick();
        n_checks++; if (x_a !== 10'd799) begin n_fail++; $display("FAIL reset_x_a got %0d want 799", x_a); end
        n_checks++; if (y_a !== 10'd524) begin n_fail++; $display("FAIL reset_y_a got %0d want 524", y_a); end
        n_checks++; if ({de_a, hs_a, vs_a, ls_a, fs_a} !== 5'b01100) begin n_fail++; $display("FAIL reset_out_a got %b want 01100", {de_a, hs_a, vs_a, ls_a, fs_a}); end
        n_checks++; if (x_b !== 5'd15 || y_b !== 5'd11) begin n_fail++; $display("FAIL reset_xy_b got %0d,%0d want 15,11", x_b, y_b); end
        n_checks++; if ({de_b, hs_b, vs_b, ls_b, fs_b} !== 5'b00000) begin n_fail++; $display("FAIL reset_out_b got %b want 00000", {de_b, hs_b, vs_b, ls_b, fs_b}); end
        n_checks++; if ({de_c, hs_c, vs_c, ls_c, fs_c} !== 5'b01100) begin n_fail++; $display("FAIL reset_out_c got %b want 01100", {de_c, hs_c, vs_c, ls_c, fs_c}); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (x_a !== 10'd799 || y_a !== 10'd524) begin n_fail++; $display("FAIL frozen_no_en got %0d,%0d want 799,524", x_a, y_a); end
    endtask

    task automatic test_first_pixel();
        pix_en_a = 1'b1;
        tick();
        n_checks++; if (x_a !== 10'd0 || y_a !== 10'd0) begin n_fail++; $display("FAIL first_xy got %0d,%0d want 0,0", x_a, y_a); end
        n_checks++; if ({de_a, hs_a, vs_a, ls_a, fs_a} !== 5'b11111) begin n_fail++; $display("FAIL first_out got %b want 11111", {de_a, hs_a, vs_a, ls_a, fs_a}); end
        tick();
        n_checks++; if (x_a !== 10'd1) begin n_fail++; $display("FAIL second_x got %0d want 1", x_a); end
        n_checks++; if (ls_a !== 1'b0 || fs_a !== 1'b0) begin n_fail++; $display("FAIL strobe_width got %b%b want 00", ls_a, fs_a); end
    endtask

    task automatic test_horizontal();
        int hs_low = 0;
        int last_ls = 0;
        logic exp_de, exp_hs, exp_ls;
        int ex, ey;
        pix_en_a = 1'b1;
        for (int e = 2; e <= 800; e++) begin
            tick();
            ex = e % 800; ey = e / 800;
            exp_de = (ex < 640) && (ey < 480);
            exp_hs = !((ex >= 656) && (ex < 752));
            exp_ls = (ex == 0);
            if (hs_a === 1'b0) hs_low++;
            if (ls_a === 1'b1) last_ls = e;
            n_checks++; if (x_a !== 10'(ex) || y_a !== 10'(ey)) begin n_fail++; $display("FAIL h_xy e=%0d got %0d,%0d want %0d,%0d", e, x_a, y_a, ex, ey); end
            n_checks++; if (de_a !== exp_de) begin n_fail++; $display("FAIL h_de x=%0d got %b want %b", ex, de_a, exp_de); end
            n_checks++; if (hs_a !== exp_hs) begin n_fail++; $display("FAIL h_hsync x=%0d got %b want %b", ex, hs_a, exp_hs); end
            n_checks++; if (ls_a !== exp_ls) begin n_fail++; $display("FAIL h_line_start x=%0d got %b want %b", ex, ls_a, exp_ls); end
        end
        pix_en_a = 1'b0;
        n_checks++; if (hs_low != 96) begin n_fail++; $display("FAIL hsync_width got %0d want 96", hs_low); end
        n_checks++; if (last_ls != 800) begin n_fail++; $display("FAIL line_period got %0d want 800", last_ls); end
    endtask

    task automatic test_vertical();
        int vs_high = 0;
        int fs_prev = -1;
        int fs_period = 0;
        int ex, ey;
        logic exp_de, exp_hs, exp_vs, exp_ls, exp_fs;
        pix_en_b = 1'b1;
        for (int e = 0; e < 384; e++) begin
            tick();
            ex = e % 16; ey = (e / 16) % 12;
            exp_de = (ex < 8) && (ey < 6);
            exp_hs = (ex >= 10) && (ex < 13);
            exp_vs = (ey >= 8) && (ey < 10);
            exp_ls = (ex == 0);
            exp_fs = (ex == 0) && (ey == 0);
            if (e < 192 && vs_b === 1'b1) vs_high++;
            if (fs_b === 1'b1) begin
                if (fs_prev >= 0) fs_period = e - fs_prev;
                fs_prev = e;
            end
            n_checks++; if (x_b !== 5'(ex) || y_b !== 5'(ey)) begin n_fail++; $display("FAIL v_xy e=%0d got %0d,%0d want %0d,%0d", e, x_b, y_b, ex, ey); end
            n_checks++; if ({de_b, hs_b, vs_b, ls_b, fs_b} !== {exp_de, exp_hs, exp_vs, exp_ls, exp_fs}) begin
                n_fail++; $display("FAIL v_out x=%0d y=%0d got %b want %b", ex, ey, {de_b, hs_b, vs_b, ls_b, fs_b}, {exp_de, exp_hs, exp_vs, exp_ls, exp_fs});
            end
        end
        pix_en_b = 1'b0;
        n_checks++; if (vs_high != 32) begin n_fail++; $display("FAIL vsync_width got %0d want 32", vs_high); end
        n_checks++; if (fs_period != 192) begin n_fail++; $display("FAIL frame_period got %0d want 192", fs_period); end
    endtask

    task automatic test_half_rate();
        int fs_prev = -1;
        int fs_period = 0;
        int ex, ey;
        logic exp_de, exp_hs, exp_vs, exp_ls, exp_fs;
        for (int e = 384; e <= 576; e++) begin
            pix_en_b = 1'b1;
            tick();
            ex = e % 16; ey = (e / 16) % 12;
            exp_de = (ex < 8) && (ey < 6);
            exp_hs = (ex >= 10) && (ex < 13);
            exp_vs = (ey >= 8) && (ey < 10);
            exp_ls = (ex == 0);
            exp_fs = (ex == 0) && (ey == 0);
            if (fs_b === 1'b1) begin
                if (fs_prev >= 0) fs_period = e - fs_prev;
                fs_prev = e;
            end
            n_checks++; if (x_b !== 5'(ex) || y_b !== 5'(ey) || {de_b, hs_b, vs_b, ls_b, fs_b} !== {exp_de, exp_hs, exp_vs, exp_ls, exp_fs}) begin
                n_fail++; $display("FAIL half_en e=%0d got %0d,%0d %b want %0d,%0d %b", e, x_b, y_b, {de_b, hs_b, vs_b, ls_b, fs_b}, ex, ey, {exp_de, exp_hs, exp_vs, exp_ls, exp_fs});
            end
            pix_en_b = 1'b0;
            tick();
            n_checks++; if (x_b !== 5'(ex) || y_b !== 5'(ey) || {de_b, hs_b, vs_b, ls_b, fs_b} !== {exp_de, exp_hs, exp_vs, 2'b00}) begin
                n_fail++; $display("FAIL half_idle e=%0d got %0d,%0d %b want %0d,%0d %b", e, x_b, y_b, {de_b, hs_b, vs_b, ls_b, fs_b}, ex, ey, {exp_de, exp_hs, exp_vs, 2'b00});
            end
        end
        n_checks++; if (fs_period != 192) begin n_fail++; $display("FAIL half_frame_period got %0d want 192", fs_period); end
    endtask

    task automatic test_pipeline();
        int de_fall_x = -1;
        int hs_on_x = -1;
        int fs_x = -1;
        int fs_y = -1;
        int ex, ey, dx, dy;
        logic prev_de = 1'b0;
        logic exp_de, exp_hs, exp_ls, exp_fs;
        pix_en_c = 1'b1;
        for (int e = 0; e <= 805; e++) begin
            tick();
            ex = e % 800; ey = e / 800;
            if (e < 2) begin
                exp_de = 1'b0; exp_hs = 1'b1; exp_ls = 1'b0; exp_fs = 1'b0;
            end else begin
                dx = (e - 2) % 800; dy = (e - 2) / 800;
                exp_de = (dx < 640) && (dy < 480);
                exp_hs = !((dx >= 656) && (dx < 752));
                exp_ls = (dx == 0);
                exp_fs = (dx == 0) && (dy == 0);
            end
            if (prev_de === 1'b1 && de_c === 1'b0 && de_fall_x < 0) de_fall_x = int'(x_c);
            if (hs_c === 1'b0 && hs_on_x < 0) hs_on_x = int'(x_c);
            if (fs_c === 1'b1 && fs_x < 0) begin fs_x = int'(x_c); fs_y = int'(y_c); end
            prev_de = de_c;
            n_checks++; if (x_c !== 10'(ex) || y_c !== 10'(ey)) begin n_fail++; $display("FAIL p_xy e=%0d got %0d,%0d want %0d,%0d", e, x_c, y_c, ex, ey); end
            n_checks++; if ({de_c, hs_c, vs_c, ls_c, fs_c} !== {exp_de, exp_hs, 1'b1, exp_ls, exp_fs}) begin
                n_fail++; $display("FAIL p_out e=%0d got %b want %b", e, {de_c, hs_c, vs_c, ls_c, fs_c}, {exp_de, exp_hs, 1'b1, exp_ls, exp_fs});
            end
        end
        pix_en_c = 1'b0;
        n_checks++; if (de_fall_x != 642) begin n_fail++; $display("FAIL p_de_fall got x=%0d want 642", de_fall_x); end
        n_checks++; if (hs_on_x != 658) begin n_fail++; $display("FAIL p_hsync_on got x=%0d want 658", hs_on_x); end
        n_checks++; if (fs_x != 2 || fs_y != 0) begin n_fail++; $display("FAIL p_frame_start got %0d,%0d want 2,0", fs_x, fs_y); end
    endtask

    task automatic test_reset_midline();
        n_checks++; if (x_a !== 10'd0 || y_a !== 10'd1) begin n_fail++; $display("FAIL a_held got %0d,%0d want 0,1", x_a, y_a); end
        pix_en_a = 1'b1;
        repeat (300) tick();
        pix_en_a = 1'b0;
        n_checks++; if (x_a !== 10'd300 || y_a !== 10'd1 || de_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset got %0d,%0d de=%b want 300,1 de=1", x_a, y_a, de_a); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (x_a !== 10'd799 || y_a !== 10'd524) begin n_fail++; $display("FAIL async_reset_xy got %0d,%0d want 799,524", x_a, y_a); end
        n_checks++; if ({de_a, hs_a, vs_a, ls_a, fs_a} !== 5'b01100) begin n_fail++; $display("FAIL async_reset_out got %b want 01100", {de_a, hs_a, vs_a, ls_a, fs_a}); end
        tick();
        rst_n = 1'b1;
        tick();
        pix_en_a = 1'b1;
        tick();
        pix_en_a = 1'b0;
        n_checks++; if (x_a !== 10'd0 || y_a !== 10'd0 || {de_a, ls_a, fs_a} !== 3'b111) begin
            n_fail++; $display("FAIL post_reset got %0d,%0d de/ls/fs=%b want 0,0 111", x_a, y_a, {de_a, ls_a, fs_a});
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_horizontal();
        test_vertical();
        test_half_rate();
        test_pipeline();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
